// File: rtl/ram_16to8_pkg.sv
// Shared default geometry for the ram_16to8 simple dual-port memory.
package ram_16to8_pkg;

  localparam int WIDTH_DEF = 8;
  localparam int DEPTH_DEF = 16;
  localparam int ADDR_DEF  = 4;

endpackage

// File: rtl/ram_16to8.sv
// Simple dual-port flop-based RAM: one write and one registered read per cycle,
// write-first on same-address collision, whole array cleared by async reset.
module ram_16to8
  import ram_16to8_pkg::*;
#(
  parameter int width = WIDTH_DEF,
  parameter int depth = DEPTH_DEF,
  parameter int addr  = ADDR_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [addr-1:0]  wr_addr,
  input  logic [width-1:0] wr_data,
  input  logic             re,
  input  logic [addr-1:0]  rd_addr,
  output logic [width-1:0] d_out
);

  logic [width-1:0] mem_reg [depth];
  logic [depth-1:0] wr_sel;
  logic             bypass;

  // One-hot write decode, one select line per word.
  generate
    for (genvar gi = 0; gi < depth; gi++) begin : g_wr_sel
      assign wr_sel[gi] = we && (wr_addr == addr'(gi));
    end
  endgenerate

  assign bypass = we && (wr_addr == rd_addr);

  // Write port; flops (not block RAM) so reset can clear every word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < depth; i++) begin
        mem_reg[i] <= '0;
      end
    end else begin
      for (int i = 0; i < depth; i++) begin
        if (wr_sel[i]) begin
          mem_reg[i] <= wr_data;
        end
      end
    end
  end

  // Read port; a same-address write is forwarded so the read sees new data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      d_out <= '0;
    end else if (re) begin
      d_out <= bypass ? wr_data : mem_reg[rd_addr];
    end
  end

endmodule

// File: tb/tb_ram_16to8.sv
// Self-checking bench for ram_16to8: directed vector table, reset sequences,
// and randomized traffic against a simple array model.
module tb_ram_16to8;
  import ram_16to8_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       we;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic       re;
  logic [3:0] rd_addr;
  logic [7:0] d_out;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic       we;
    logic [3:0] wa;
    logic [7:0] wd;
    logic       re;
    logic [3:0] ra;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[$];

  logic [7:0] model_mem [16];
  logic [7:0] model_dout;

  ram_16to8 #(
    .width(WIDTH_DEF),
    .depth(DEPTH_DEF),
    .addr (ADDR_DEF)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .we     (we),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .re     (re),
    .rd_addr(rd_addr),
    .d_out  (d_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: d_out=%02h expected %02h", name, act, exp);
    end
  endtask

  // Drive one transaction at the falling edge, then sample just after the rising edge.
  task automatic cycle(input logic w, input logic [3:0] wa, input logic [7:0] wd,
                       input logic r, input logic [3:0] ra);
    @(negedge clk);
    we = w; wr_addr = wa; wr_data = wd; re = r; rd_addr = ra;
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 16; i++) model_mem[i] = 8'h00;
    model_dout = 8'h00;
  endtask

  // Reference behaviour: a read returns the word as it is after this cycle's write.
  task automatic model_step(input logic w, input logic [3:0] wa, input logic [7:0] wd,
                            input logic r, input logic [3:0] ra);
    if (w) model_mem[wa] = wd;
    if (r) model_dout = model_mem[ra];
  endtask

  initial begin
    rst = 1'b0; we = 1'b0; wr_addr = '0; wr_data = '0; re = 1'b0; rd_addr = '0;
    #2;
    check("reset_dout", d_out, 8'h00);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    // Directed table: write/read, hold, collision, boundaries, parallel access.
    vecs.push_back('{1'b1, 4'd1,  8'hAA, 1'b0, 4'd0,  8'h00});
    vecs.push_back('{1'b1, 4'd2,  8'hBB, 1'b0, 4'd0,  8'h00});
    vecs.push_back('{1'b1, 4'd3,  8'hCC, 1'b0, 4'd0,  8'h00});
    vecs.push_back('{1'b0, 4'd0,  8'h00, 1'b1, 4'd1,  8'hAA});
    vecs.push_back('{1'b0, 4'd0,  8'h00, 1'b1, 4'd2,  8'hBB});
    vecs.push_back('{1'b0, 4'd0,  8'h00, 1'b1, 4'd3,  8'hCC});
    vecs.push_back('{1'b0, 4'd0,  8'h00, 1'b0, 4'd1,  8'hCC});
    vecs.push_back('{1'b0, 4'd0,  8'h00, 1'b0, 4'd1,  8'hCC});
    vecs.push_back('{1'b0, 4'd0,  8'h00, 1'b0, 4'd1,  8'hCC});
    vecs.push_back('{1'b1, 4'd4,  8'h5A, 1'b1, 4'd4,  8'h5A});
    vecs.push_back('{1'b0, 4'd0,  8'h00, 1'b1, 4'd4,  8'h5A});
    vecs.push_back('{1'b1, 4'd0,  8'h11, 1'b0, 4'd0,  8'h5A});
    vecs.push_back('{1'b1, 4'd15, 8'hFF, 1'b0, 4'd0,  8'h5A});
    vecs.push_back('{1'b0, 4'd0,  8'h00, 1'b1, 4'd0,  8'h11});
    vecs.push_back('{1'b0, 4'd0,  8'h00, 1'b1, 4'd15, 8'hFF});
    vecs.push_back('{1'b0, 4'd0,  8'h00, 1'b1, 4'd1,  8'hAA});
    vecs.push_back('{1'b0, 4'd0,  8'h00, 1'b1, 4'd14, 8'h00});
    vecs.push_back('{1'b1, 4'd7,  8'h77, 1'b1, 4'd2,  8'hBB});
    vecs.push_back('{1'b0, 4'd0,  8'h00, 1'b1, 4'd7,  8'h77});
    vecs.push_back('{1'b0, 4'd0,  8'h00, 1'b1, 4'd6,  8'h00});
    vecs.push_back('{1'b0, 4'd0,  8'h00, 1'b1, 4'd8,  8'h00});

    foreach (vecs[i]) begin
      cycle(vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].re, vecs[i].ra);
      $display("vec %0d: we=%0b wa=%0d wd=%02h re=%0b ra=%0d -> d_out=%02h exp=%02h",
               i, vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].re, vecs[i].ra, d_out, vecs[i].exp);
      check($sformatf("vec%0d", i), d_out, vecs[i].exp);
    end

    // Reset clear: write 0x55@5, confirm, then pulse reset mid-cycle with traffic in flight.
    cycle(1'b1, 4'd5, 8'h55, 1'b0, 4'd0);
    cycle(1'b0, 4'd0, 8'h00, 1'b1, 4'd5);
    $display("rst_seq: read 5 before reset -> d_out=%02h", d_out);
    check("pre_reset_read5", d_out, 8'h55);
    @(negedge clk);
    we = 1'b1; wr_addr = 4'd5; wr_data = 8'h99; re = 1'b1; rd_addr = 4'd5;
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    $display("rst_seq: async assert -> d_out=%02h", d_out);
    check("async_reset_dout", d_out, 8'h00);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      $display("rst_seq: held in reset cycle %0d -> d_out=%02h", k, d_out);
      check($sformatf("reset_hold%0d", k), d_out, 8'h00);
    end
    // First edge after release is fully operational (collision write-first here).
    @(negedge clk);
    rst = 1'b1;
    we = 1'b1; wr_addr = 4'd9; wr_data = 8'h3C; re = 1'b1; rd_addr = 4'd9;
    @(posedge clk);
    #1;
    $display("rst_seq: first edge after release -> d_out=%02h", d_out);
    check("first_edge_after_release", d_out, 8'h3C);
    for (int a = 0; a < 16; a++) begin
      cycle(1'b0, 4'd0, 8'h00, 1'b1, 4'(a));
      $display("sweep: read %0d -> d_out=%02h", a, d_out);
      check($sformatf("post_reset_read%0d", a), d_out, (a == 9) ? 8'h3C : 8'h00);
    end

    // Randomized traffic from a clean reset, compared against the model.
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rand_reset_dout", d_out, 8'h00);
    @(negedge clk);
    rst = 1'b1;
    model_clear();
    for (int n = 0; n < 300; n++) begin
      logic       w, r;
      logic [3:0] wa, ra;
      logic [7:0] wd;
      w  = 1'($urandom_range(0, 1));
      r  = 1'($urandom_range(0, 1));
      wa = 4'($urandom_range(0, 15));
      ra = ($urandom_range(0, 3) == 0) ? wa : 4'($urandom_range(0, 15));
      wd = 8'($urandom);
      cycle(w, wa, wd, r, ra);
      model_step(w, wa, wd, r, ra);
      $display("rand %0d: we=%0b wa=%0d wd=%02h re=%0b ra=%0d -> d_out=%02h exp=%02h",
               n, w, wa, wd, r, ra, d_out, model_dout);
      check($sformatf("rand%0d", n), d_out, model_dout);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ram_16to8.md
RAM_16TO8 -- requirements
Module: ram_16to8

Interface
REQ-001 The block SHALL have parameter width, default 8, meaning data word width in bits.
REQ-002 The block SHALL have parameter depth, default 16, meaning number of memory locations.
REQ-003 The block SHALL have parameter addr, default 4, meaning address width in bits, with depth == 2**addr.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset (asserted when 0).
REQ-006 The block SHALL have port we, input, 1 bit: write enable, sampled at the rising clk edge.
REQ-007 The block SHALL have port wr_addr, input, addr bits: write address.
REQ-008 The block SHALL have port wr_data, input, width bits: write data.
REQ-009 The block SHALL have port re, input, 1 bit: read enable, sampled at the rising clk edge.
REQ-010 The block SHALL have port rd_addr, input, addr bits: read address.
REQ-011 The block SHALL have port d_out, output, width bits: registered read data.

Function
REQ-012 Storage SHALL be depth x width bits, independently addressed by the write port and the read port (simple dual-port: one write, one read per cycle).
REQ-013 Write: when we=1 at a rising clk edge, mem[wr_addr] SHALL take wr_data at that edge; when we=0, memory SHALL be unchanged.
REQ-014 Read: when re=1 at a rising clk edge, d_out SHALL take mem[rd_addr] at that edge (latency 1 cycle: valid after the edge that samples re).
REQ-015 When re=0 at an edge, d_out SHALL hold its previous value.
REQ-016 Same-cycle collision (we=1, re=1, wr_addr==rd_addr): d_out SHALL return the new wr_data (write-first); the memory SHALL also store wr_data.
REQ-017 Simultaneous read and write to different addresses SHALL both complete in the same cycle without interference.
REQ-018 All addr-bit address values 0..depth-1 SHALL be valid; there is no out-of-range case and no wrap logic.
REQ-019 Inputs with X/undefined enables SHALL NOT be required to be handled; enables are assumed driven 0/1 by the environment.

Reset
REQ-020 While rst=0, d_out SHALL be 0 immediately (asynchronous), independent of clk.
REQ-021 While rst=0, every memory location SHALL be cleared to 0, and writes and reads SHALL be ignored.
REQ-022 After rst returns to 1, the first rising edge SHALL operate normally (a write or read at that edge takes effect).
REQ-023 Reset asserted mid-operation SHALL discard any in-flight access; the memory SHALL read back 0 everywhere after release.

Structure
REQ-024 Default values of width, depth and addr SHALL be defined as constants in a shared package (ram_16to8_pkg), with the module parameters defaulting to them.
REQ-025 The design SHALL be a single module with no sub-module; the memory array SHALL be flop-based, so that the reset clear of REQ-021 is possible.
REQ-026 The write logic and the read/output logic SHALL be coded as separate sequential processes.

Verification
REQ-027 Reset then write: after reset, writing 0xAA@1, 0xBB@2, 0xCC@3 on consecutive cycles followed by reads of addresses 1, 2, 3 SHALL give d_out = 0xAA, 0xBB, 0xCC, each one cycle after the corresponding re edge.
REQ-028 Reset clear: after writing 0x55@5 and pulsing rst=0, a read of address 5 SHALL give d_out = 0x00, and d_out SHALL be 0x00 during reset.
REQ-029 Collision: with we=1 and re=1, wr_addr = rd_addr = 4 and wr_data = 0x5A, d_out SHALL be 0x5A after the edge, and a later read of address 4 SHALL give 0x5A.
REQ-030 Hold: after reading 0xCC@3, driving re=0 with rd_addr=1 for 3 cycles SHALL keep d_out = 0xCC.
REQ-031 Boundary addresses: writing 0x11@0 and 0xFF@15 SHALL read back 0x11 and 0xFF, and neighbouring locations SHALL be unaffected.
REQ-032 Parallel access: writing 0x77@7 while reading address 2 (holding 0xBB) in the same cycle SHALL give d_out = 0xBB, and a subsequent read of address 7 SHALL give 0x77.
